julia_collector: RTL and testbench
==================================

Name: julia_collector

Overview:
- Collects finished pixels from NUM_JULIA Julia worker blocks and serialises them to the frame-buffer write master.
- Replaces the single-grant search mux with four additions: a fair round-robin arbiter, a per-worker ack handshake, an output FIFO and frame-level sequencing.
- Sits between the worker array and the SRAM/AHB writer.

Parameters:
- NUM_JULIA, 8, number of worker channels (≥2)
- ADDR_W, 32, pixel address width
- DATA_W, 8, pixel data width
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
- FRAME_PIXELS, 307200, pixels per frame (640x480)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begins a frame
- done  in  NUM_JULIA  worker i has a valid pixel; held until acked
- cat_addr  in  NUM_JULIA*ADDR_W  worker i address at bits [i*ADDR_W +: ADDR_W]
- cat_pixel  in  NUM_JULIA*DATA_W  worker i pixel at bits [i*DATA_W +: DATA_W]
- ack  out  NUM_JULIA  one-hot or zero; pixel taken from worker i this cycle
- wr_valid  out  1  FIFO head valid
- wr_ready  in  1  writer accepts head
- wr_addr  out  ADDR_W  head address
- wr_data  out  DATA_W  head pixel
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when the last frame pixel is accepted downstream

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, rr_ptr=0, FIFO count/pointers=0, pixel counter=0. Outputs: ack=0, wr_valid=0, frame_done=0, busy=0. wr_addr/wr_data are don't-care.
- Reset asserted mid-frame discards FIFO contents and all counts. Workers keep done asserted and are served after the next start.
- FSM states:
  - IDLE: ack=0. start → COLLECT; the pixel counter clears on that edge.
  - COLLECT: arbitration enabled. When a grant makes the accepted count reach FRAME_PIXELS → DRAIN on the same edge. No further acks after that.
  - DRAIN: ack=0. When FIFO is empty and not pushing → IDLE, with frame_done pulsed in that transition cycle (registered, high for exactly one cycle).
  - start is ignored outside IDLE.
- Arbitration (COLLECT only):
  - grant = first i with done[i]=1, searching from rr_ptr upward and wrapping modulo NUM_JULIA.
  - A grant is issued only if the FIFO is not full at the start of the cycle. A simultaneous pop does not free the slot, so there is no wr_ready→ack combinational path.
  - ack[grant] is combinational in the same cycle. The handshake completes at the rising edge where done[i]&ack[i]=1.
  - Worker may present a new pixel (done held) or drop done on the following cycle.
  - On grant: rr_ptr ← (grant+1) mod NUM_JULIA. No grant → rr_ptr unchanged.
  - At most one grant per cycle; throughput is 1 pixel/cycle.
- FIFO:
  - Push on grant. Pop on wr_valid&wr_ready. Simultaneous push/pop keeps count.
  - wr_valid = count!=0. wr_addr/wr_data are driven from registered storage at the read pointer and stay stable while wr_valid&!wr_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency from ack edge to wr_valid is 1 cycle when the FIFO was empty.
- Pixel counter: width $clog2(FRAME_PIXELS+1), increments on each grant, no wrap.
- done bits from workers not in COLLECT state are left pending, never dropped.

Optional Feature:
- Macro JULIA_COLLECT_STATS_EN.
- Defined: adds output stall_cycles (32-bit).
  - Counts COLLECT cycles with |done=1 and no grant (FIFO full).
  - Saturates at all-ones and clears on start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- julia_pkg holds:
  - collector_state_t enum {IDLE, COLLECT, DRAIN}
  - default constants NUM_JULIA=8, ADDR_W=32, DATA_W=8
  - FRAME_PIXELS
- One sub-module, julia_rr_arbiter (params N), is natural:
  - inputs req[N], en; output one-hot gnt[N]
  - owns rr_ptr; replaces mask_gen
- FIFO stays inline.

Test Plan:
- Reset mid-COLLECT with 3 entries queued → wr_valid=0, ack=0, busy=0 next cycle. After start, counts restart from 0.
- All 8 done held high, wr_ready=1 → acks in order 0,1,...,7,0. Exactly one ack per cycle. wr_addr sequence matches cat_addr slices.
- wr_ready=0, done=8'hFF → exactly 4 acks (FIFO_DEPTH), then ack=0. With stats enabled, stall_cycles increments each cycle. wr_addr is held stable.
- done=8'b1000_0001 with rr_ptr=1 → grant 7, rr_ptr becomes 0, then grant 0 next cycle.
- FRAME_PIXELS=10 build, continuous done, writer ready every other cycle → exactly 10 acks, then DRAIN. frame_done pulses once after the 10th pop, and busy falls the same cycle.
- start pulse while busy → ignored. Pixel counter and FIFO are unaffected.

Source files
------------

// File: rtl/julia_pkg.sv
// -----------------------------------------------------------------------------
// julia_pkg
// Shared types and default constants for the Julia pixel collector.
//   collector_state_t : collector frame sequencing states
//   DEF_*             : default build parameters (8 workers, 32-bit address,
//                       8-bit pixel, 4-entry FIFO, 640x480 frame)
// -----------------------------------------------------------------------------
package julia_pkg;

  localparam int DEF_NUM_JULIA    = 8;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } collector_state_t;

endpackage

// File: rtl/julia_rr_arbiter.sv
// -----------------------------------------------------------------------------
// julia_rr_arbiter
// Fair round-robin arbiter. Searches req upward from rr_ptr, wrapping modulo N,
// and grants the first requester. rr_ptr moves past the winner on a grant and
// holds otherwise.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (rr_ptr -> 0)
//   req[N]   : request vector
//   en       : arbitration enable; gnt is zero when low
//   gnt[N]   : one-hot (or zero) grant, combinational
// -----------------------------------------------------------------------------
module julia_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] idx;
  logic [PTR_W:0]   sum;
  logic             found;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    next_ptr = rr_ptr;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      // Candidate index (rr_ptr + k) mod N; N need not be a power of two.
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = (idx == PTR_W'(N-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_ptr <= '0;
    else if (found) rr_ptr <= next_ptr;
  end

endmodule

// File: rtl/julia_collector.sv
// -----------------------------------------------------------------------------
// julia_collector
// Collects finished pixels from NUM_JULIA Julia workers through a round-robin
// arbiter, buffers them in a small FIFO and presents them to the frame-buffer
// writer. Frame sequencing: IDLE -> COLLECT (FRAME_PIXELS grants) -> DRAIN
// (FIFO empties) -> IDLE with a one-cycle frame_done pulse.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle pulse, begins a frame (IDLE only)
//   done[NUM_JULIA]     : worker i holds a valid pixel until acked
//   cat_addr, cat_pixel : packed per-worker address / pixel
//   ack[NUM_JULIA]      : one-hot or zero, pixel taken from worker i this cycle
//   wr_valid/wr_ready   : FIFO head handshake to the writer
//   wr_addr, wr_data    : FIFO head contents
//   busy                : state != IDLE
//   frame_done          : one-cycle pulse when the frame has fully drained
//   stall_cycles        : (JULIA_COLLECT_STATS_EN only) saturating count of
//                         COLLECT cycles with a pending done and no grant
// Optional build macro: JULIA_COLLECT_STATS_EN
// -----------------------------------------------------------------------------
module julia_collector
  import julia_pkg::*;
#(
  parameter int NUM_JULIA    = DEF_NUM_JULIA,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_JULIA-1:0]        done,
  input  logic [NUM_JULIA*ADDR_W-1:0] cat_addr,
  input  logic [NUM_JULIA*DATA_W-1:0] cat_pixel,
  output logic [NUM_JULIA-1:0]        ack,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        busy,
  output logic                        frame_done
`ifdef JULIA_COLLECT_STATS_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PIX_W = $clog2(FRAME_PIXELS + 1);

  collector_state_t state_q, state_d;
  logic             frame_done_d;

  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PIX_W-1:0] pix_cnt;

  logic full, arb_en, push, pop, last_pixel;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  // Fullness is judged on the registered count only, so a pop in the same
  // cycle never frees a slot and wr_ready has no combinational path to ack.
  assign full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign arb_en = (state_q == COLLECT) && !full;

  julia_rr_arbiter #(.N(NUM_JULIA)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (done),
    .en  (arb_en),
    .gnt (ack)
  );

  assign push       = |ack;
  assign pop        = wr_valid && wr_ready;
  assign last_pixel = push && (pix_cnt == PIX_W'(FRAME_PIXELS - 1));

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (last_pixel) state_d = DRAIN;
      DRAIN: begin
        if (fifo_cnt == '0 && !push) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= frame_done_d;
    end
  end

  // Accepted-pixel counter; COLLECT leaves on the grant that reaches
  // FRAME_PIXELS, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          pix_cnt <= '0;
    else if (state_q == IDLE && start) pix_cnt <= '0;
    else if (push)                    pix_cnt <= pix_cnt + 1'b1;
  end

  // Select the granted worker's slice; ack is one-hot so OR-ing is exact.
  always_comb begin
    in_addr = '0;
    in_data = '0;
    for (int i = 0; i < NUM_JULIA; i++) begin
      if (ack[i]) begin
        in_addr = in_addr | cat_addr[i*ADDR_W +: ADDR_W];
        in_data = in_data | cat_pixel[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by fifo_cnt
  // alone, which keeps the memory free of reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign wr_valid = (fifo_cnt != '0);
  assign wr_addr  = addr_mem[rd_ptr];
  assign wr_data  = data_mem[rd_ptr];
  assign busy     = (state_q != IDLE);

`ifdef JULIA_COLLECT_STATS_EN
  // In COLLECT a pending done without a grant can only mean the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (state_q == IDLE && start)
      stall_cycles <= '0;
    else if (state_q == COLLECT && |done && !push && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_julia_collector.sv
// -----------------------------------------------------------------------------
// tb_julia_collector
// Scoreboard bench for julia_collector built with FRAME_PIXELS=10. The driver
// checks ack against directed expectations and queues the expected pixel; a
// monitor pops and compares on every accepted wr_valid/wr_ready beat.
// Honours JULIA_COLLECT_STATS_EN for the stall_cycles port.
// -----------------------------------------------------------------------------
module tb_julia_collector;

  localparam int NJ = 8;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int FP = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NJ-1:0]    done;
  logic [NJ*AW-1:0] cat_addr;
  logic [NJ*DW-1:0] cat_pixel;
  logic [NJ-1:0]    ack;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             busy;
  logic             frame_done;
`ifdef JULIA_COLLECT_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  int unsigned seq [NJ] = '{default: 0};

  always #5 clk = ~clk;

  julia_collector #(
    .NUM_JULIA(NJ), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .FRAME_PIXELS(FP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .done       (done),
    .cat_addr   (cat_addr),
    .cat_pixel  (cat_pixel),
    .ack        (ack),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef JULIA_COLLECT_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  function automatic logic [AW-1:0] addr_of(input int g, input int unsigned s);
    return {8'hA0, 8'(g), 16'(s)};
  endfunction

  function automatic logic [DW-1:0] pix_of(input int g, input int unsigned s);
    return 8'((g << 5) | (s & 31));
  endfunction

  // Worker model: each worker advances to a fresh pixel after a handshake.
  always @(posedge clk) begin
    for (int i = 0; i < NJ; i++)
      if (done[i] && ack[i]) seq[i] <= seq[i] + 1;
  end

  always_comb begin
    cat_addr  = '0;
    cat_pixel = '0;
    for (int i = 0; i < NJ; i++) begin
      cat_addr[i*AW +: AW]  = addr_of(i, seq[i]);
      cat_pixel[i*DW +: DW] = pix_of(i, seq[i]);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check ack mid-cycle and
  // queue the pixel the expected winner is presenting.
  task automatic step(input logic st, input logic [NJ-1:0] d, input logic rdy,
                      input logic [NJ-1:0] exp_ack);
    exp_t e;
    @(posedge clk);
    #1;
    start    = st;
    done     = d;
    wr_ready = rdy;
    @(negedge clk);
    check("ack", 64'(ack), 64'(exp_ack));
    for (int i = 0; i < NJ; i++) begin
      if (exp_ack[i]) begin
        e.addr = addr_of(i, seq[i]);
        e.data = pix_of(i, seq[i]);
        sb_q.push_back(e);
      end
    end
  endtask

  // Monitor: every beat the writer accepts must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && wr_valid && wr_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got beat addr=%0h with no expected entry", wr_addr);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; done = '0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    rst = 1'b0;

    // Reset mid-COLLECT with three entries queued.
    step(1'b1, 8'h00, 1'b0, 8'h00);
    step(1'b0, 8'h07, 1'b0, 8'h01);
    step(1'b0, 8'h07, 1'b0, 8'h02);
    step(1'b0, 8'h07, 1'b0, 8'h04);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    check("a_busy", 64'(busy), 64'(1));
    check("a_wr_valid", 64'(wr_valid), 64'(1));
    done = 8'h07;
    rst  = 1'b1;
    #1;
    check("a_rst_wr_valid", 64'(wr_valid), 64'(0));
    check("a_rst_ack", 64'(ack), 64'(0));
    check("a_rst_busy", 64'(busy), 64'(0));
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // All workers pending, writer always ready: 0..7,0,1 then DRAIN.
    step(1'b1, 8'hFF, 1'b1, 8'h00);
    for (int k = 0; k < FP; k++) step(1'b0, 8'hFF, 1'b1, 8'(1 << (k % NJ)));
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("b_drain_busy", 64'(busy), 64'(1));
    check("b_drain_valid", 64'(wr_valid), 64'(1));
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("b_pre_frame_done", 64'(frame_done), 64'(0));
    check("b_pre_busy", 64'(busy), 64'(1));
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("b_frame_done", 64'(frame_done), 64'(1));
    check("b_idle_busy", 64'(busy), 64'(0));
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("b_frame_done_1cyc", 64'(frame_done), 64'(0));

    // Writer stalled: four grants fill the FIFO, then no acks, head held.
    step(1'b1, 8'hFF, 1'b0, 8'h00);
    for (int k = 2; k < 6; k++) step(1'b0, 8'hFF, 1'b0, 8'(1 << k));
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 8'hFF, 1'b0, 8'h00);
      check("c_head_valid", 64'(wr_valid), 64'(1));
      check("c_head_addr", 64'(wr_addr), 64'(addr_of(2, seq[2] - 1)));
`ifdef JULIA_COLLECT_STATS_EN
      check("c_stall", 64'(stall_cycles), 64'(s));
`endif
    end
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 8'hFF, 1'b1, 8'(1 << ((6 + k) % NJ)));
`ifdef JULIA_COLLECT_STATS_EN
      if (k == 0) check("c_stall_release", 64'(stall_cycles), 64'(4));
`endif
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("c_pre_frame_done", 64'(frame_done), 64'(0));
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("c_frame_done", 64'(frame_done), 64'(1));
    check("c_idle_busy", 64'(busy), 64'(0));

    // Wrap from rr_ptr=1 with workers 7 and 0; start ignored while busy.
    step(1'b1, 8'h00, 1'b1, 8'h00);
    step(1'b0, 8'h01, 1'b1, 8'h01);
`ifdef JULIA_COLLECT_STATS_EN
    check("d_stall_cleared", 64'(stall_cycles), 64'(0));
`endif
    step(1'b0, 8'h81, 1'b1, 8'h80);
    step(1'b0, 8'h81, 1'b1, 8'h01);
    step(1'b1, 8'h00, 1'b1, 8'h00);
    check("d_start_ignored_busy", 64'(busy), 64'(1));
    for (int k = 1; k < NJ; k++) step(1'b0, 8'hFF, 1'b1, 8'(1 << k));
    step(1'b1, 8'hFF, 1'b1, 8'h00);
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("d_pre_busy", 64'(busy), 64'(1));
    step(1'b0, 8'hFF, 1'b1, 8'h00);
    check("d_frame_done", 64'(frame_done), 64'(1));
    check("d_idle_busy", 64'(busy), 64'(0));

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
